// File: rtl/sequence_checker.sv
// Receive-side checker for an arithmetic-progression data stream.
// Acquires lock on consecutive samples that differ by STEP, then flags and counts deviations.
module sequence_checker #(
    parameter int DATA_W   = 8,
    parameter int STEP     = 1,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 8,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] data,
    input  logic              clear,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_count,
    output logic [CNT_W-1:0]  word_count,
    output logic [DATA_W-1:0] expected
);

    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = (LOSS_CNT < 2) ? 1 : $clog2(LOSS_CNT + 1);

    localparam logic [DATA_W-1:0] STEP_V    = DATA_W'(STEP);
    localparam logic [RUN_W-1:0]  LOCK_LAST = RUN_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_CNT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   expected_q, expected_d;
    logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
    logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
    logic [ERR_W-1:0]    err_count_q, err_count_d;
    logic [CNT_W-1:0]    word_count_q, word_count_d;
    logic                err_pulse_q, err_pulse_d;
    logic                locked_q, locked_d;

    logic                match;
    logic                err_inc;
    logic                word_inc;

    always_comb begin
        state_d      = state_q;
        expected_d   = expected_q;
        run_cnt_d    = run_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;
        err_pulse_d  = 1'b0;
        err_inc      = 1'b0;
        word_inc     = 1'b0;
        match        = (data == expected_q);

        if (enable) begin
            unique case (state_q)
                IDLE: begin
                    expected_d = data + STEP_V;
                    run_cnt_d  = RUN_W'(1);
                    state_d    = ACQUIRE;
                end
                ACQUIRE: begin
                    if (match) begin
                        expected_d = expected_q + STEP_V;
                        run_cnt_d  = run_cnt_q + RUN_W'(1);
                        if (run_cnt_q == LOCK_LAST) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        expected_d = data + STEP_V;
                        run_cnt_d  = RUN_W'(1);
                    end
                end
                LOCKED: begin
                    word_inc = 1'b1;
                    if (match) begin
                        expected_d = expected_q + STEP_V;
                        miss_cnt_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        // Losing lock restarts acquisition from the offending word.
                        if (miss_cnt_q == MISS_LAST) begin
                            state_d    = ACQUIRE;
                            expected_d = data + STEP_V;
                            run_cnt_d  = RUN_W'(1);
                            miss_cnt_d = '0;
                        end else begin
                            expected_d = expected_q + STEP_V;
                            miss_cnt_d = miss_cnt_q + MISS_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (err_inc && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
        if (word_inc) begin
            word_count_d = word_count_q + CNT_W'(1);
        end
        if (clear) begin
            err_count_d  = '0;
            word_count_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            expected_q   <= '0;
            run_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            err_count_q  <= '0;
            word_count_q <= '0;
            err_pulse_q  <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            expected_q   <= expected_d;
            run_cnt_q    <= run_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
            err_pulse_q  <= err_pulse_d;
            locked_q     <= locked_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign word_count = word_count_q;
    assign expected   = expected_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: directed scenarios plus random traffic, checked every
// cycle against an anchor-based model of the progression the checker should be tracking.
module tb_sequence_checker;

    localparam int DATA_W   = 8;
    localparam int STEP     = 1;
    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int ERR_W    = 4;
    localparam int CNT_W    = 16;
    localparam int ERR_MAX  = (1 << ERR_W) - 1;

    logic              clk    = 1'b0;
    logic              reset  = 1'b1;
    logic              enable = 1'b0;
    logic [DATA_W-1:0] data   = '0;
    logic              clear  = 1'b0;
    logic              locked;
    logic              err_pulse;
    logic [ERR_W-1:0]  err_count;
    logic [CNT_W-1:0]  word_count;
    logic [DATA_W-1:0] expected;

    int n_vec  = 0;
    int n_fail = 0;

    sequence_checker #(
        .DATA_W  (DATA_W),
        .STEP    (STEP),
        .LOCK_CNT(LOCK_CNT),
        .LOSS_CNT(LOSS_CNT),
        .ERR_W   (ERR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .data      (data),
        .clear     (clear),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .word_count(word_count),
        .expected  (expected)
    );

    always #5 clk = ~clk;

    // The model follows the stream as anchor + since*STEP: anchor is the word that
    // started the current run, since is how many enabled samples have passed since then.
    bit              m_valid;
    bit              m_locked;
    bit              m_pulse;
    logic [7:0]      m_anchor;
    logic [7:0]      m_expected;
    int              m_since;
    int              m_misses;
    int              m_err;
    int              m_words;

    task automatic model_zero();
        m_valid = 0; m_locked = 0; m_pulse = 0;
        m_anchor = '0; m_expected = '0;
        m_since = 0; m_misses = 0; m_err = 0; m_words = 0;
    endtask

    task automatic model_update();
        bit hit;
        m_pulse = 0;
        if (enable) begin
            hit = m_valid && (data == m_expected);
            if (!m_valid) begin
                m_valid = 1; m_anchor = data; m_since = 1;
            end else if (!m_locked) begin
                if (hit) begin
                    m_since++;
                    if (m_since == LOCK_CNT) begin
                        m_locked = 1; m_misses = 0;
                    end
                end else begin
                    m_anchor = data; m_since = 1;
                end
            end else begin
                m_words++;
                m_since++;
                if (hit) m_misses = 0;
                else begin
                    m_pulse = 1;
                    m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
                    m_misses++;
                    if (m_misses == LOSS_CNT) begin
                        m_locked = 0; m_anchor = data; m_since = 1; m_misses = 0;
                    end
                end
            end
        end
        if (clear) begin
            m_err = 0; m_words = 0;
        end
        m_expected = m_valid ? 8'(m_anchor + m_since * STEP) : 8'h00;
    endtask

    initial begin
        model_zero();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_zero();
            else model_update();
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                check_output("locked",     32'(locked),     32'(m_locked));
                check_output("err_pulse",  32'(err_pulse),  32'(m_pulse));
                check_output("err_count",  32'(err_count),  32'(m_err));
                check_output("word_count", 32'(word_count), 32'(m_words[CNT_W-1:0]));
                check_output("expected",   32'(expected),   32'(m_expected));
            end
        end
    end

    task automatic apply_stimulus(input logic en, input logic [7:0] d, input logic clr);
        enable = en; data = d; clear = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [CNT_W-1:0] wc0;
    int               pulses;

    initial begin
        #1 reset = 1'b0;
        #2;
        check_output("reset_locked",   32'(locked),     32'h0);
        check_output("reset_errcnt",   32'(err_count),  32'h0);
        check_output("reset_wordcnt",  32'(word_count), 32'h0);
        check_output("reset_expected", 32'(expected),   32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Acquire from 00
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 8'(i), 1'b0);
        check_output("t1_locked",   32'(locked),    32'h1);
        check_output("t1_expected", 32'(expected),  32'h04);
        check_output("t1_errcnt",   32'(err_count), 32'h0);

        // Run through the wrap point
        for (int i = 4; i <= 'hFB; i++) apply_stimulus(1'b1, 8'(i), 1'b0);
        wc0 = word_count;
        pulses = 0;
        for (int i = 'hFC; i <= 'h101; i++) begin
            apply_stimulus(1'b1, 8'(i), 1'b0);
            pulses += int'(err_pulse);
        end
        check_output("t2_pulses",  32'(pulses),             32'h0);
        check_output("t2_locked",  32'(locked),             32'h1);
        check_output("t2_wcdelta", 32'(16'(word_count - wc0)), 32'h6);

        // Single glitch is flywheeled over
        for (int i = 2; i <= 'hF; i++) apply_stimulus(1'b1, 8'(i), 1'b0);
        apply_stimulus(1'b1, 8'h10, 1'b0);
        apply_stimulus(1'b1, 8'hAA, 1'b0);
        check_output("t3_pulse",    32'(err_pulse), 32'h1);
        apply_stimulus(1'b1, 8'h12, 1'b0);
        check_output("t3_errcnt",   32'(err_count), 32'h1);
        check_output("t3_locked",   32'(locked),    32'h1);
        check_output("t3_expected", 32'(expected),  32'h13);

        // Repeated lock loss until the error counter saturates
        for (int r = 0; r < 6; r++) begin
            repeat (3) apply_stimulus(1'b1, 8'h77, 1'b0);
            check_output("t4_unlocked", 32'(locked), 32'h0);
            for (int i = 'h78; i <= 'h7B; i++) apply_stimulus(1'b1, 8'(i), 1'b0);
            check_output("t4_relocked", 32'(locked), 32'h1);
        end
        check_output("t4_errsat", 32'(err_count), 32'(ERR_MAX));

        // Gaps in enable are invisible
        repeat (5) apply_stimulus(1'b0, 8'($urandom), 1'b0);
        apply_stimulus(1'b1, 8'h7C, 1'b0);
        apply_stimulus(1'b1, 8'h7D, 1'b0);
        check_output("t5_locked", 32'(locked),    32'h1);
        check_output("t5_errcnt", 32'(err_count), 32'(ERR_MAX));

        // Clear, build err_count=2, then asynchronous reset mid-cycle
        apply_stimulus(1'b1, 8'h7E, 1'b1);
        check_output("t6_cleared", 32'(err_count), 32'h0);
        apply_stimulus(1'b1, 8'h00, 1'b0);
        apply_stimulus(1'b1, 8'h01, 1'b0);
        check_output("t6_err2",   32'(err_count), 32'h2);
        check_output("t6_locked", 32'(locked),    32'h1);
        apply_stimulus(1'b1, 8'h81, 1'b0);
        enable = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_output("t6_rst_locked",   32'(locked),     32'h0);
        check_output("t6_rst_errcnt",   32'(err_count),  32'h0);
        check_output("t6_rst_wordcnt",  32'(word_count), 32'h0);
        check_output("t6_rst_expected", 32'(expected),   32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 8'(i), 1'b0);
        apply_stimulus(1'b1, 8'h55, 1'b1);
        check_output("t6_clr_errcnt", 32'(err_count),  32'h0);
        check_output("t6_clr_pulse",  32'(err_pulse),  32'h1);
        check_output("t6_clr_wc",     32'(word_count), 32'h0);

        // Random traffic: mostly on-sequence words, with glitches, gaps and clears
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 5) == 0) ? 8'($urandom) : m_expected;
            apply_stimulus(($urandom_range(0, 7) != 0), d, ($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
